// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM behind a valid/ready request/response
// handshake. It serves one load or store at a time after WAIT_CYCLES wait
// states. Byte lanes are big-endian within each 32-bit word.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// half and word accesses fault. When it is undefined, the misaligned low
// address bits are forced to zero.

module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  state_t              state;
  logic [3:0]          wait_cnt;
  logic                lat_wr;
  logic [1:0]          lat_size;
  logic [ADDR_W+1:0]   lat_addr;
  logic [31:0]         lat_wdata;

  logic [31:0]         mem [2**ADDR_W];

  logic                acc_wr;
  logic [1:0]          acc_size;
  logic [ADDR_W+1:0]   acc_addr;
  logic [31:0]         acc_wdata;
  logic [ADDR_W-1:0]   word_idx;
  logic [1:0]          eff_lo;
  logic [31:0]         cur_word;
  logic [31:0]         new_word;
  logic [31:0]         load_data;
  logic                acc_err;
  logic [31:0]         rdata_next;
  logic                do_access;
  logic                mem_we;

  // Address bits above the RAM depth wrap away; they are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  // Pick the access source (a zero-wait access uses the live request), then compute the merged store word, the load data and the fault flag.
  always_comb begin
    acc_wr     = lat_wr;
    acc_size   = lat_size;
    acc_addr   = lat_addr;
    acc_wdata  = lat_wdata;
    if (state == S_IDLE) begin
      acc_wr    = req_wr;
      acc_size  = req_size;
      acc_addr  = req_addr[ADDR_W+1:0];
      acc_wdata = req_wdata;
    end

    word_idx  = acc_addr[ADDR_W+1:2];
    cur_word  = mem[word_idx];
    eff_lo    = acc_addr[1:0];
    acc_err   = 1'b0;
    new_word  = cur_word;
    load_data = 32'd0;

`ifdef MISALIGN_TRAP_EN
    if ((acc_size == SZ_WORD && acc_addr[1:0] != 2'b00) ||
        (acc_size == SZ_HALF && acc_addr[0])) begin
      acc_err = 1'b1;
    end
`else
    if (acc_size == SZ_WORD) begin
      eff_lo = 2'b00;
    end else if (acc_size == SZ_HALF) begin
      eff_lo[0] = 1'b0;
    end
`endif

    case (acc_size)
      SZ_WORD: begin
        new_word  = acc_wdata;
        load_data = cur_word;
      end
      SZ_HALF: begin
        if (!eff_lo[1]) begin
          new_word  = {acc_wdata[15:0], cur_word[15:0]};
          load_data = {16'd0, cur_word[31:16]};
        end else begin
          new_word  = {cur_word[31:16], acc_wdata[15:0]};
          load_data = {16'd0, cur_word[15:0]};
        end
      end
      SZ_BYTE: begin
        case (eff_lo)
          2'd0: begin
            new_word  = {acc_wdata[7:0], cur_word[23:0]};
            load_data = {24'd0, cur_word[31:24]};
          end
          2'd1: begin
            new_word  = {cur_word[31:24], acc_wdata[7:0], cur_word[15:0]};
            load_data = {24'd0, cur_word[23:16]};
          end
          2'd2: begin
            new_word  = {cur_word[31:16], acc_wdata[7:0], cur_word[7:0]};
            load_data = {24'd0, cur_word[15:8]};
          end
          default: begin
            new_word  = {cur_word[31:8], acc_wdata[7:0]};
            load_data = {24'd0, cur_word[7:0]};
          end
        endcase
      end
      default: begin
        acc_err = 1'b1;
      end
    endcase

    rdata_next = (acc_wr || acc_err) ? 32'd0 : load_data;

    do_access = (state == S_WAIT && wait_cnt == 4'd0) ||
                (state == S_IDLE && req_valid && ZERO_WAIT);
    mem_we    = do_access && acc_wr && !acc_err && !reset;
  end

  // Storage is never reset; a store commits only on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_idx] <= new_word;
    end
  end

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      lat_wr     <= 1'b0;
      lat_size   <= 2'b00;
      lat_addr   <= '0;
      lat_wdata  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_wr    <= req_wr;
            lat_size  <= req_size;
            lat_addr  <= req_addr[ADDR_W+1:0];
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (ZERO_WAIT) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= rdata_next;
              resp_err   <= acc_err;
            end else begin
              wait_cnt <= WAIT_LOAD;
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= rdata_next;
            resp_err   <= acc_err;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder with default parameters (ADDR_W=8, WAIT_CYCLES=1).
// Expected values are hand-computed. The misaligned-load vector follows
// MISALIGN_TRAP_EN when that macro is defined for the build.

module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[18];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: waits for req_ready, issues the request, measures the latency,
  // holds the response for hold_cycles with resp_ready low, then completes the handshake.
  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input int hold_cycles,
                               input logic [31:0] exp_rdata, input logic exp_err, input string name);
    int guard;
    int lat;
    guard = 0;
    while (!req_ready && guard < 20) begin
      stepCycle();
      guard++;
    end
    checkOutput({name, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    stepCycle();
    req_valid = 1'b0;
    req_wdata = 32'd0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      stepCycle();
      lat++;
    end
    checkOutput({name, "_lat"}, lat, 32'd2);
    checkOutput({name, "_rdata"}, resp_rdata, exp_rdata);
    checkOutput({name, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    for (int i = 0; i < hold_cycles; i++) begin
      stepCycle();
      checkOutput({name, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
      checkOutput({name, "_hold_rdata"}, resp_rdata, exp_rdata);
      checkOutput({name, "_hold_reqrdy"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    stepCycle();
    resp_ready = 1'b0;
    checkOutput({name, "_idle_valid"}, {31'd0, resp_valid}, 32'd0);
    checkOutput({name, "_idle_reqrdy"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_wr     = 1'b0;
    req_size   = 2'b00;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b0;

    vecs[0]  = '{1'b1, 2'b00, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, "st_w_10"};
    vecs[1]  = '{1'b0, 2'b00, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, "ld_w_10"};
    vecs[2]  = '{1'b1, 2'b00, 32'h10,  32'h11223344, 32'h0,        1'b0, "st_w_10b"};
    vecs[3]  = '{1'b1, 2'b10, 32'h11,  32'hFFFFFFAA, 32'h0,        1'b0, "st_b_11"};
    vecs[4]  = '{1'b0, 2'b00, 32'h10,  32'h0,        32'h11AA3344, 1'b0, "ld_w_merge"};
    vecs[5]  = '{1'b0, 2'b10, 32'h11,  32'h0,        32'h000000AA, 1'b0, "ld_b_11"};
    vecs[6]  = '{1'b0, 2'b10, 32'h13,  32'h0,        32'h00000044, 1'b0, "ld_b_13"};
    vecs[7]  = '{1'b0, 2'b01, 32'h10,  32'h0,        32'h000011AA, 1'b0, "ld_h_10"};
    vecs[8]  = '{1'b0, 2'b01, 32'h12,  32'h0,        32'h00003344, 1'b0, "ld_h_12"};
    vecs[9]  = '{1'b1, 2'b01, 32'h12,  32'hFFFFBEEF, 32'h0,        1'b0, "st_h_12"};
    vecs[10] = '{1'b0, 2'b00, 32'h10,  32'h0,        32'h11AABEEF, 1'b0, "ld_w_half"};
    vecs[11] = '{1'b0, 2'b00, 32'h410, 32'h0,        32'h11AABEEF, 1'b0, "ld_w_alias"};
    vecs[12] = '{1'b1, 2'b11, 32'h10,  32'h0,        32'h0,        1'b1, "st_rsvd"};
    vecs[13] = '{1'b0, 2'b00, 32'h10,  32'h0,        32'h11AABEEF, 1'b0, "ld_w_after_rsvd"};
`ifdef MISALIGN_TRAP_EN
    vecs[14] = '{1'b0, 2'b00, 32'h12,  32'h0,        32'h0,        1'b1, "ld_w_misalign"};
`else
    vecs[14] = '{1'b0, 2'b00, 32'h12,  32'h0,        32'h11AABEEF, 1'b0, "ld_w_misalign"};
`endif
    vecs[15] = '{1'b1, 2'b00, 32'h14,  32'h0,        32'h0,        1'b0, "st_w_14"};
    vecs[16] = '{1'b1, 2'b10, 32'h17,  32'hFFFFFF5A, 32'h0,        1'b0, "st_b_17"};
    vecs[17] = '{1'b0, 2'b00, 32'h14,  32'h0,        32'h0000005A, 1'b0, "ld_w_14"};

    // Reset state
    stepCycle();
    stepCycle();
    reset = 1'b0;
    stepCycle();
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);

    // Table-driven vectors
    for (int v = 0; v < 18; v++) begin
      applyStimulus(vecs[v].wr, vecs[v].size, vecs[v].addr, vecs[v].wdata, 0,
                    vecs[v].exp_rdata, vecs[v].exp_err, vecs[v].name);
    end

    // Backpressure: response held for 5 cycles must stay stable
    applyStimulus(1'b0, 2'b00, 32'h10, 32'h0, 5, 32'h11AABEEF, 1'b0, "backpressure");

    // Reset during WAIT of a store must leave the old contents intact
    applyStimulus(1'b1, 2'b00, 32'h20, 32'hCAFEF00D, 0, 32'h0, 1'b0, "st_w_20");
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    stepCycle();
    req_valid = 1'b0;
    checkOutput("wait_reqrdy", {31'd0, req_ready}, 32'd0);
    checkOutput("wait_valid", {31'd0, resp_valid}, 32'd0);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    stepCycle();
    checkOutput("midrst_resp_valid2", {31'd0, resp_valid}, 32'd0);
    applyStimulus(1'b0, 2'b00, 32'h20, 32'h0, 0, 32'hCAFEF00D, 1'b0, "ld_w_20_after_rst");

    // Load immediately after store to the same address
    applyStimulus(1'b1, 2'b10, 32'h20, 32'h00000099, 0, 32'h0, 1'b0, "st_b_20");
    applyStimulus(1'b0, 2'b00, 32'h20, 32'h0, 0, 32'h99FEF00D, 1'b0, "ld_w_20_raw");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
